// File: rtl/glacial_mem_arb_if.sv
// Bus bundle for glacial_mem_arb: core port, host four-phase port and memory port.
// The arbiter takes the slave view; whatever drives the core/host and owns the RAM takes master.
interface glacial_mem_arb_if;
    logic [15:0] cpu_addr;
    logic        cpu_rd_en;
    logic        cpu_wr_en;
    logic [7:0]  cpu_wr_data;
    logic [7:0]  cpu_rd_data;

    logic        host_req;
    logic        host_we;
    logic [15:0] host_addr;
    logic [7:0]  host_wr_data;
    logic        host_ack;
    logic        host_err;
    logic [7:0]  host_rd_data;
    logic        host_busy;

    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_data;
    logic [7:0]  mem_rd_data;

    modport slave (
        input  cpu_addr, cpu_rd_en, cpu_wr_en, cpu_wr_data,
        input  host_req, host_we, host_addr, host_wr_data,
        input  mem_rd_data,
        output cpu_rd_data,
        output host_ack, host_err, host_rd_data, host_busy,
        output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
    );

    modport master (
        output cpu_addr, cpu_rd_en, cpu_wr_en, cpu_wr_data,
        output host_req, host_we, host_addr, host_wr_data,
        output mem_rd_data,
        input  cpu_rd_data,
        input  host_ack, host_err, host_rd_data, host_busy,
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/glacial_mem_arb.sv
// Single-port memory arbiter: the core always wins, the host steals idle core cycles.
// Define GLACIAL_ARB_STATS_EN to add the steal_count output (host accesses issued).
module glacial_mem_arb #(
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    glacial_mem_arb_if.slave   bus
`ifdef GLACIAL_ARB_STATS_EN
    ,
    output logic [15:0]        steal_count
`endif
);
    typedef enum logic [1:0] {IDLE, PEND, ISSUED, ACK} state_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wr_data;
    } host_req_t;

    state_t    state, state_nx;
    host_req_t req_q;
    logic      armed;
    logic [7:0] wait_cnt, wait_cnt_inc;
    logic      cpu_act, accept, host_issue, timed_out;

    assign cpu_act      = bus.cpu_rd_en | bus.cpu_wr_en;
    assign accept       = (state == IDLE) && bus.host_req && armed;
    assign host_issue   = (state == PEND) && !cpu_act;
    assign wait_cnt_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    // Give up once the incremented wait count hits TIMEOUT; zero means wait forever.
    assign timed_out    = (TIMEOUT != 0) && (state == PEND) && cpu_act &&
                          (int'(wait_cnt_inc) >= TIMEOUT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = PEND;
            PEND:    if (!cpu_act) state_nx = ISSUED;
                     else if (timed_out) state_nx = ACK;
            ISSUED:  state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_addr    = bus.cpu_addr;
        bus.mem_wr_data = bus.cpu_wr_data;
        bus.mem_rd_en   = bus.cpu_rd_en;
        bus.mem_wr_en   = bus.cpu_wr_en;
        if (host_issue) begin
            bus.mem_addr    = req_q.addr;
            bus.mem_wr_data = req_q.wr_data;
            bus.mem_rd_en   = ~req_q.we;
            bus.mem_wr_en   = req_q.we;
        end
    end

    assign bus.host_busy   = (state != IDLE);
    assign bus.cpu_rd_data = bus.mem_rd_data;

    // armed re-opens only after host_req has been seen low, so a held request fires once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed    <= 1'b1;
            wait_cnt <= 8'd0;
            req_q    <= '0;
        end else begin
            if (!bus.host_req) armed <= 1'b1;
            else if (accept)   armed <= 1'b0;
            if (accept) begin
                req_q    <= '{we: bus.host_we, addr: bus.host_addr, wr_data: bus.host_wr_data};
                wait_cnt <= 8'd0;
            end else if ((state == PEND) && cpu_act) begin
                wait_cnt <= wait_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.host_ack     <= 1'b0;
            bus.host_err     <= 1'b0;
            bus.host_rd_data <= 8'h00;
        end else begin
            bus.host_ack <= (state_nx == ACK);
            bus.host_err <= timed_out;
            if ((state == ISSUED) && !req_q.we) bus.host_rd_data <= bus.mem_rd_data;
        end
    end

`ifdef GLACIAL_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        steal_count <= 16'd0;
        else if (host_issue) steal_count <= steal_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_glacial_mem_arb.sv
// Scoreboard bench for glacial_mem_arb: two instances (TIMEOUT 64 and 4) share one random
// stimulus stream; each has its own RAM model and its own transaction-level expectations.
module tb_glacial_mem_arb;
    localparam int T0 = 64;
    localparam int T1 = 4;

    typedef struct { int cyc; bit err; bit we; logic [7:0] data; } ack_t;
    typedef struct { int cyc; bit we; logic [15:0] addr; logic [7:0] data; } strb_t;
    typedef struct { int cyc; logic [7:0] data; } crd_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] cpu_addr = '0;
    logic        cpu_rd_en = 1'b0, cpu_wr_en = 1'b0;
    logic [7:0]  cpu_wr_data = '0;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [15:0] host_addr = '0;
    logic [7:0]  host_wr_data = '0;

    logic [1:0]       ack_w, err_w, busy_w, mrd_w, mwr_w;
    logic [1:0][7:0]  hrd_w, crd_w, mwd_w;
    logic [1:0][15:0] madr_w, sc_w;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   tmo [2] = '{T0, T1};
    int   exp_steal [2] = '{0, 0};
    logic [7:0] shadow [2][0:65535];
    ack_t  ackq [2][$];
    strb_t stq  [2][$];
    crd_t  crq  [2][$];

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return (a == 16'h0123) ? 8'h5A : (a[7:0] ^ a[15:8] ^ 8'h3C);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        glacial_mem_arb_if bus();
        logic [7:0] mem [0:65535];
        bit         wrn [0:65535];
        logic [7:0] rdq;
        logic [15:0] sc;

        assign bus.cpu_addr     = cpu_addr;
        assign bus.cpu_rd_en    = cpu_rd_en;
        assign bus.cpu_wr_en    = cpu_wr_en;
        assign bus.cpu_wr_data  = cpu_wr_data;
        assign bus.host_req     = host_req;
        assign bus.host_we      = host_we;
        assign bus.host_addr    = host_addr;
        assign bus.host_wr_data = host_wr_data;
        assign bus.mem_rd_data  = rdq;

        // Synchronous RAM, read-before-write, unwritten locations return init_val.
        always @(posedge clk) begin
            if (bus.mem_wr_en) begin
                mem[bus.mem_addr] <= bus.mem_wr_data;
                wrn[bus.mem_addr] <= 1'b1;
            end
            if (bus.mem_rd_en)
                rdq <= wrn[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
        end

        glacial_mem_arb #(.TIMEOUT(g == 0 ? T0 : T1)) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus)
`ifdef GLACIAL_ARB_STATS_EN
            ,
            .steal_count (sc)
`endif
        );
`ifndef GLACIAL_ARB_STATS_EN
        assign sc = 16'd0;
`endif
        assign ack_w[g]  = bus.host_ack;
        assign err_w[g]  = bus.host_err;
        assign busy_w[g] = bus.host_busy;
        assign hrd_w[g]  = bus.host_rd_data;
        assign crd_w[g]  = bus.cpu_rd_data;
        assign mrd_w[g]  = bus.mem_rd_en;
        assign mwr_w[g]  = bus.mem_wr_en;
        assign madr_w[g] = bus.mem_addr;
        assign mwd_w[g]  = bus.mem_wr_data;
        assign sc_w[g]   = sc;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic fail_evt(input string nm, input int at);
        n_cmp++;
        n_bad++;
        $display("FAIL %s @cyc %0d: got event, expected none", nm, at);
    endtask

    // Monitor: samples 2 time units after the falling edge, clear of the stimulus updates.
    always @(negedge clk) begin
        ack_t  ea;
        strb_t es;
        crd_t  ec;
        #2;
        for (int g = 0; g < 2; g++) begin
            if (ack_w[g]) begin
                if (ackq[g].size() == 0) fail_evt($sformatf("ack_unexpected_u%0d", g), cyc);
                else begin
                    ea = ackq[g].pop_front();
                    chk($sformatf("ack_cycle_u%0d", g), cyc, ea.cyc);
                    chk($sformatf("host_err_u%0d", g), {31'd0, err_w[g]}, {31'd0, ea.err});
                    if (!ea.err && !ea.we)
                        chk($sformatf("host_rd_data_u%0d", g), {24'd0, hrd_w[g]}, {24'd0, ea.data});
                end
            end
            while (ackq[g].size() > 0 && ackq[g][0].cyc < cyc) begin
                ea = ackq[g].pop_front();
                fail_evt($sformatf("ack_missing_u%0d", g), ea.cyc);
            end
            if ((mrd_w[g] | mwr_w[g]) && !(cpu_rd_en | cpu_wr_en)) begin
                if (stq[g].size() == 0) fail_evt($sformatf("strobe_unexpected_u%0d", g), cyc);
                else begin
                    es = stq[g].pop_front();
                    chk($sformatf("strobe_cycle_u%0d", g), cyc, es.cyc);
                    chk($sformatf("strobe_we_u%0d", g), {30'd0, mwr_w[g], mrd_w[g]}, {30'd0, es.we, !es.we});
                    chk($sformatf("strobe_addr_u%0d", g), {16'd0, madr_w[g]}, {16'd0, es.addr});
                    if (es.we) chk($sformatf("strobe_data_u%0d", g), {24'd0, mwd_w[g]}, {24'd0, es.data});
                end
            end
            while (stq[g].size() > 0 && stq[g][0].cyc < cyc) begin
                es = stq[g].pop_front();
                fail_evt($sformatf("strobe_missing_u%0d", g), es.cyc);
            end
            while (crq[g].size() > 0 && crq[g][0].cyc <= cyc) begin
                ec = crq[g].pop_front();
                chk($sformatf("cpu_rd_data_u%0d", g), {24'd0, crd_w[g]}, {24'd0, ec.data});
            end
        end
    end

    task automatic core_cycle(input bit busy);
        logic [15:0] a;
        logic [7:0]  d;
        bit          w;
        a = 16'($urandom_range(0, 63));
        d = 8'($urandom);
        w = 1'($urandom_range(0, 1));
        cpu_rd_en   = busy & !w;
        cpu_wr_en   = busy & w;
        cpu_addr    = a;
        cpu_wr_data = d;
        if (busy)
            for (int g = 0; g < 2; g++) begin
                if (w) shadow[g][a] = d;
                else   crq[g].push_back('{cyc + 1, shadow[g][a]});
            end
    endtask

    // One host transaction: core busy for L cycles from PEND entry, host_req dropped at hold_k.
    task automatic do_txn(input bit we, input logic [15:0] a, input logic [7:0] d,
                          input int L, input int hold_k);
        int n;
        bit done;
        done = 1'b0;
        @(negedge clk);
        n = cyc;
        host_req = 1'b1; host_we = we; host_addr = a; host_wr_data = d;
        core_cycle(L > 0);
        for (int g = 0; g < 2; g++)
            if (tmo[g] != 0 && L >= tmo[g]) ackq[g].push_back('{n + 1 + tmo[g], 1'b1, we, 8'h00});
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == L + 1)
                for (int g = 0; g < 2; g++)
                    if (!(tmo[g] != 0 && L >= tmo[g])) begin
                        stq[g].push_back('{cyc, we, a, d});
                        ackq[g].push_back('{cyc + 2, 1'b0, we, we ? 8'h00 : shadow[g][a]});
                        if (we) shadow[g][a] = d;
                        exp_steal[g]++;
                    end
            core_cycle(k <= L);
            host_req = (k < hold_k);
            if (k > L + 1 && k > hold_k && busy_w == 2'b00) begin
                done = 1'b1;
                break;
            end
        end
        chk("txn_completes_in_budget", {31'd0, done}, 32'd1);
`ifdef GLACIAL_ARB_STATS_EN
        for (int g = 0; g < 2; g++)
            chk($sformatf("steal_count_u%0d", g), {16'd0, sc_w[g]}, exp_steal[g]);
`endif
    endtask

    initial begin
        int L, hk;
        for (int g = 0; g < 2; g++)
            for (int a = 0; a < 65536; a++) shadow[g][a] = init_val(16'(a));

        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst_busy_u%0d", g), {31'd0, busy_w[g]}, 32'd0);
            chk($sformatf("rst_ack_u%0d", g), {31'd0, ack_w[g]}, 32'd0);
            chk($sformatf("rst_err_u%0d", g), {31'd0, err_w[g]}, 32'd0);
            chk($sformatf("rst_rd_data_u%0d", g), {24'd0, hrd_w[g]}, 32'd0);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        do_txn(1'b0, 16'h0123, 8'h00, 0, 1);      // best-case read
        do_txn(1'b1, 16'h0040, 8'hC3, 10, 1);     // core busy 10 cycles; u1 times out
        do_txn(1'b0, 16'h0011, 8'h00, 6, 3);      // u1 times out on a read
        do_txn(1'b0, 16'h0040, 8'h00, 0, 23);     // held request: one access only
        do_txn(1'b0, 16'h0040, 8'h00, 2, 1);      // reasserted: second access

        // Reset while PEND with the core busy: no ack, busy drops at once.
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
        core_cycle(1'b1);
        @(negedge clk); core_cycle(1'b1);
        @(negedge clk); core_cycle(1'b1);
        #1 reset_n = 1'b0; host_req = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("midrst_busy_u%0d", g), {31'd0, busy_w[g]}, 32'd0);
            chk($sformatf("midrst_rd_data_u%0d", g), {24'd0, hrd_w[g]}, 32'd0);
        end
        #1 reset_n = 1'b1;
        exp_steal = '{0, 0};
        repeat (8) begin
            @(negedge clk);
            core_cycle(1'b0);
        end
        do_txn(1'b0, 16'h0040, 8'h00, 0, 1);

        for (int t = 0; t < 40; t++) begin
            L  = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 12) : $urandom_range(0, 3);
            hk = ($urandom_range(0, 1) == 1) ? 1 : $urandom_range(1, L + 8);
            do_txn(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 8'($urandom), L, hk);
        end

        repeat (4) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("ackq_drained_u%0d", g), ackq[g].size(), 32'd0);
            chk($sformatf("stq_drained_u%0d", g), stq[g].size(), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/glacial_mem_arb.md
GLACIAL_MEM_ARB -- requirements
Module: glacial_mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 64, max cycles a host request waits in PEND; 0 disables timeout.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 cpu_addr  input  16  core memory address.
REQ-005 cpu_rd_en, cpu_wr_en  input  1 each  core read/write strobes.
REQ-006 cpu_wr_data  input  8  core write data.
REQ-007 cpu_rd_data  output  8  equals mem_rd_data, combinational pass-through.
REQ-008 host_req  input  1  host request level, four-phase handshake.
REQ-009 host_we  input  1  host write (1) or read (0).
REQ-010 host_addr  input  16  host address.
REQ-011 host_wr_data  input  8  host write data.
REQ-012 host_ack  output  1  registered, one-cycle completion pulse.
REQ-013 host_err  output  1  registered, valid with host_ack, 1 = timed out, not performed.
REQ-014 host_rd_data  output  8  registered read result, valid from host_ack onward.
REQ-015 host_busy  output  1  high whenever state is not IDLE.
REQ-016 mem_addr  output  16, mem_rd_en  output  1, mem_wr_en  output  1, mem_wr_data  output  8: memory port.
REQ-017 mem_rd_data  input  8  synchronous memory data, valid the cycle after mem_rd_en.

Function
REQ-018 Core has absolute priority: any cycle with cpu_rd_en|cpu_wr_en drives mem_* from cpu_* combinationally, same cycle.
REQ-019 States: IDLE, PEND, ISSUED, ACK.
REQ-020 IDLE->PEND when host_req=1 and armed=1; host_we/addr/wr_data latched; armed cleared; wait counter cleared.
REQ-021 armed set on any cycle host_req=0; a held host_req never starts a second access.
REQ-022 PEND with cpu_rd_en=0 and cpu_wr_en=0: mem_* driven from latched host fields that same cycle (mem_rd_en=~we, mem_wr_en=we); next state ISSUED.
REQ-023 PEND with core active: counter increments (8-bit, saturating); when TIMEOUT!=0 and counter reaches TIMEOUT, next state ACK with error, no memory access.
REQ-024 ISSUED: for reads, host_rd_data <= mem_rd_data; writes leave host_rd_data unchanged; next state ACK.
REQ-025 ACK: host_ack=1 for exactly one cycle, host_err set per REQ-023 else 0; next state IDLE.
REQ-026 Best-case latency: accept cycle N, issue N+1, host_ack N+3.
REQ-027 No memory outputs active when core idle and state not PEND: mem_rd_en=mem_wr_en=0, mem_addr=cpu_addr, mem_wr_data=cpu_wr_data.
REQ-028 Core access starting in ISSUED or ACK is unaffected; host data path never interferes.
REQ-029 host_req dropped while PEND: access still completes and acks.

Reset
REQ-030 reset_n=0 asynchronously forces IDLE, armed=1, counter=0, host_ack=0, host_err=0, host_rd_data=8'h00.
REQ-031 Reset mid-operation discards pending request; no ack issued for it.

Configuration
REQ-032 Macro GLACIAL_ARB_STATS_EN defined: adds output steal_count (16) counting host accesses issued (REQ-022), wrapping 16'hFFFF->0, reset 0.
REQ-033 GLACIAL_ARB_STATS_EN undefined: steal_count port and counter absent; all other behaviour identical.

Verification
REQ-034 Core idle, host read addr 16'h0123, mem holds 8'h5A -> mem_rd_en from host at N+1, host_ack N+3, host_rd_data=8'h5A, host_err=0.
REQ-035 Core reading every cycle for 10 cycles, host write 8'hC3 to 16'h0040 -> no host access until first idle cycle, then mem_wr_en with 16'h0040/8'hC3, ack 2 cycles later.
REQ-036 TIMEOUT=4, core continuously busy, host read -> host_ack with host_err=1 exactly 4 cycles after PEND entry, no host memory strobe.
REQ-037 host_req held high 20 cycles after ack -> exactly one access; drop then reassert -> second access.
REQ-038 reset_n pulsed low during PEND -> host_busy=0 immediately, no host_ack, subsequent request served normally.
REQ-039 GLACIAL_ARB_STATS_EN defined, three completed host accesses plus one timeout -> steal_count=3.
